fft_frame_sequencer: RTL and testbench

//  Streaming front/back-end controller for the N-point FFT core in the pak-dsp top.
//  - Collects N real samples from the src valid/ready stream into the FFT input vectors.
//  - Holds them stable for FFT_LATENCY+1 cycles, then snapshots the FFT outputs.
//  - Streams the snapshot to the dst side as 2N words. Frames do not overlap.

---
 rtl/fft_frame_sequencer.sv | 123 ++++++++++++
 tb/tb_fft_frame_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: gathers N real samples for the FFT core, waits out its
// latency, snapshots the spectrum and streams it out as Re/Im word pairs.
module fft_frame_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int N           = 8,
    parameter int FFT_LATENCY = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [DATA_WIDTH-1:0]   src_data_in,
    input  logic                    src_valid_in,
    output logic                    src_ready_out,
    output logic [N*DATA_WIDTH-1:0] fft_x_real,
    output logic [N*DATA_WIDTH-1:0] fft_x_imag,
    input  logic [N*DATA_WIDTH-1:0] fft_X_real,
    input  logic [N*DATA_WIDTH-1:0] fft_X_imag,
    output logic [DATA_WIDTH-1:0]   dst_data_out,
    output logic                    dst_valid_out,
    input  logic                    dst_ready_in,
    output logic                    busy,
    output logic                    frame_done
);
    localparam int CW = $clog2(N) + 1;
    localparam int OW = $clog2(2 * N) + 1;
    localparam int WW = $clog2(FFT_LATENCY + 1) + 1;

    typedef enum logic [1:0] {IDLE, FILL, WAIT, DRAIN} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [OW-1:0]           ocnt;
    logic [WW-1:0]           wcnt;
    logic [N*DATA_WIDTH-1:0] snap_real;
    logic [N*DATA_WIDTH-1:0] snap_imag;
    logic [OW-1:0]           onext;
    logic [DATA_WIDTH-1:0]   next_word;
    logic                    accept;
    logic                    handshake;

    assign fft_x_imag = '0;
    assign accept     = src_valid_in && src_ready_out;
    assign handshake  = dst_valid_out && dst_ready_in;

    // Even word index selects Re(bin), odd selects Im(bin); bin = index/2.
    always_comb begin
        onext = ocnt + 1'b1;
        if (onext[0])
            next_word = snap_imag[int'(onext[OW-2:1]) * DATA_WIDTH +: DATA_WIDTH];
        else
            next_word = snap_real[int'(onext[OW-2:1]) * DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            ocnt          <= '0;
            wcnt          <= '0;
            fft_x_real    <= '0;
            snap_real     <= '0;
            snap_imag     <= '0;
            dst_data_out  <= '0;
            src_ready_out <= 1'b0;
            dst_valid_out <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state         <= FILL;
                        cnt           <= '0;
                        src_ready_out <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept) begin
                        fft_x_real[int'(cnt[CW-2:0]) * DATA_WIDTH +: DATA_WIDTH] <= src_data_in;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(N - 1)) begin
                            state         <= WAIT;
                            src_ready_out <= 1'b0;
                            wcnt          <= WW'(FFT_LATENCY);
                        end
                    end
                end
                WAIT: begin
                    if (wcnt == '0) begin
                        snap_real     <= fft_X_real;
                        snap_imag     <= fft_X_imag;
                        // Word 0 is preloaded so DRAIN presents it on its first cycle.
                        dst_data_out  <= fft_X_real[DATA_WIDTH-1:0];
                        dst_valid_out <= 1'b1;
                        ocnt          <= '0;
                        state         <= DRAIN;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        if (ocnt == OW'(2 * N - 1)) begin
                            dst_valid_out <= 1'b0;
                            frame_done    <= 1'b1;
                            cnt           <= '0;
                            state         <= enable ? FILL : IDLE;
                            src_ready_out <= enable;
                            busy          <= enable;
                        end else begin
                            ocnt         <= onext;
                            dst_data_out <= next_word;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: randomized frames checked against a transaction-level
// model of accepted samples, the spectrum captured at the snapshot cycle, and word order.
module tb_fft_frame_sequencer;
    localparam int W   = 16;
    localparam int N   = 8;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [W-1:0]   src_data_in;
    logic           src_valid_in;
    logic           src_ready_out;
    logic [N*W-1:0] fft_x_real;
    logic [N*W-1:0] fft_x_imag;
    logic [N*W-1:0] fft_X_real;
    logic [N*W-1:0] fft_X_imag;
    logic [W-1:0]   dst_data_out;
    logic           dst_valid_out;
    logic           dst_ready_in;
    logic           busy;
    logic           frame_done;
    logic [W-1:0]   xr [N];
    logic [W-1:0]   xi [N];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_x
        assign fft_X_real[k*W +: W] = xr[k];
        assign fft_X_imag[k*W +: W] = xi[k];
    end

    fft_frame_sequencer #(
        .DATA_WIDTH  (W),
        .N           (N),
        .FFT_LATENCY (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .src_data_in   (src_data_in),
        .src_valid_in  (src_valid_in),
        .src_ready_out (src_ready_out),
        .fft_x_real    (fft_x_real),
        .fft_x_imag    (fft_x_imag),
        .fft_X_real    (fft_X_real),
        .fft_X_imag    (fft_X_imag),
        .dst_data_out  (dst_data_out),
        .dst_valid_out (dst_valid_out),
        .dst_ready_in  (dst_ready_in),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    task automatic chk(input string tag, input logic [N*W-1:0] got,
                       input logic [N*W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_x(input bit stub);
        for (int k = 0; k < N; k++) begin
            xr[k] = stub ? W'(10 * k) : W'($urandom);
            xi[k] = stub ? W'(-k) : W'($urandom);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_ready", src_ready_out, 0);
        chk("rst_dvalid", dst_valid_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ddata", dst_data_out, 0);
        chk("rst_xreal", fft_x_real, 0);
        chk("rst_ximag", fft_x_imag, 0);
    endtask

    // vmode: 0 valid always, 1 every 3rd cycle, 2 random.
    // rmode: 0 ready always, 1 toggling 1010, 2 random.
    task automatic run_frame(input int vmode, input int rmode,
                             input bit stub, input bit en_after);
        logic [W-1:0]   smp [N];
        logic [W-1:0]   exp_w [2*N];
        logic [N*W-1:0] pk;
        int             acc;
        int             cyc;
        int             idx;
        bit             v;
        bit             r;
        acc = 0;
        cyc = 0;
        while (acc < N && cyc < 200) begin
            chk("fill_ready", src_ready_out, 1);
            chk("fill_busy", busy, 1);
            chk("fill_dvalid", dst_valid_out, 0);
            chk("fill_done", frame_done, 0);
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            src_valid_in = v;
            src_data_in  = stub ? W'(acc + 1) : W'($urandom);
            if (v && src_ready_out) begin
                smp[acc] = src_data_in;
                acc++;
            end
            tick();
            cyc++;
        end
        if (acc < N) chk("fill_timeout", acc, N);
        for (int k = 0; k < N; k++) pk[k*W +: W] = smp[k];
        for (int c = 0; c <= LAT; c++) begin
            chk("wait_ready", src_ready_out, 0);
            chk("wait_dvalid", dst_valid_out, 0);
            chk("wait_busy", busy, 1);
            chk("wait_xreal", fft_x_real, pk);
            chk("wait_ximag", fft_x_imag, 0);
            src_valid_in = 1'($urandom_range(0, 1));
            rand_x(stub);
            if (c == LAT)
                for (int k = 0; k < N; k++) begin
                    exp_w[2*k]   = xr[k];
                    exp_w[2*k+1] = xi[k];
                end
            tick();
        end
        enable = en_after;
        idx = 0;
        cyc = 0;
        while (idx < 2 * N && cyc < 400) begin
            chk("drain_valid", dst_valid_out, 1);
            chk("drain_data", dst_data_out, exp_w[idx]);
            chk("drain_done", frame_done, 0);
            chk("drain_ready", src_ready_out, 0);
            chk("drain_xreal", fft_x_real, pk);
            rand_x(1'b0);
            src_valid_in = 1'($urandom_range(0, 1));
            r = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            dst_ready_in = r;
            if (r && dst_valid_out) idx++;
            tick();
            cyc++;
        end
        if (idx < 2 * N) chk("drain_timeout", idx, 2 * N);
        chk("end_dvalid", dst_valid_out, 0);
        chk("end_done", frame_done, 1);
        chk("end_busy", busy, en_after);
        chk("end_ready", src_ready_out, en_after);
        src_valid_in = 1'b0;
        dst_ready_in = 1'($urandom_range(0, 1));
        tick();
        chk("done_pulse", frame_done, 0);
        chk("after_busy", busy, en_after);
    endtask

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        src_valid_in = 1'b0;
        src_data_in  = '0;
        dst_ready_in = 1'b0;
        rand_x(1'b0);
        for (int i = 0; i < 3; i++) begin
            src_valid_in = 1'($urandom_range(0, 1));
            src_data_in  = W'($urandom);
            dst_ready_in = 1'($urandom_range(0, 1));
            tick();
        end
        rst          = 1'b0;
        src_valid_in = 1'b0;
        tick();
        chk_reset_state();
        enable = 1'b1;
        tick();
        chk("en_ready_1cyc", src_ready_out, 1);
        chk("en_busy", busy, 1);

        run_frame(0, 0, 1'b1, 1'b1);
        run_frame(1, 0, 1'b0, 1'b1);
        run_frame(0, 1, 1'b0, 1'b1);
        for (int f = 0; f < 6; f++) run_frame(2, 2, 1'b0, 1'b1);
        run_frame(2, 2, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_busy", busy, 0);
            chk("idle_ready", src_ready_out, 0);
        end

        enable = 1'b1;
        tick();
        chk("refill_ready", src_ready_out, 1);
        src_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src_data_in = W'($urandom);
            tick();
        end
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        src_valid_in = 1'b0;
        chk_reset_state();
        tick();
        chk("post_rst_ready", src_ready_out, 1);
        run_frame(2, 2, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
